// File: rtl/msm_seq_pkg.sv
// Shared types and default sizing for the msm_arr batch sequencer.
// MSM_MEM_SIZE is also the window size used by the test memory model.
package msm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } msm_seq_state_e;

  localparam int unsigned DEF_ADDR_WIDTH     = 16;
  localparam int unsigned MSM_MEM_SIZE       = 16;
  localparam int unsigned DEF_BATCH_WIDTH    = 8;
  localparam int unsigned DEF_CYC_WIDTH      = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/msm_seq_watchdog.sv
// Per-batch cycle counter for the batch sequencer; expired is high on the
// LIMIT-th enabled cycle after clear. Only instantiated under MSM_SEQ_WATCHDOG_EN.
module msm_seq_watchdog
  import msm_seq_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/msm_batch_sequencer.sv
// Runs the msm_arr core once per MEM_SIZE-point window for a batch command.
// Optional per-batch watchdog: define MSM_SEQ_WATCHDOG_EN.
module msm_batch_sequencer
  import msm_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned MEM_SIZE       = MSM_MEM_SIZE,
  parameter int unsigned BATCH_WIDTH    = DEF_BATCH_WIDTH,
  parameter int unsigned CYC_WIDTH      = DEF_CYC_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BATCH_WIDTH-1:0] cmd_num_batches,
  input  logic [ADDR_WIDTH-1:0]  cmd_base_addr,
  input  logic                   abort,
  output logic                   msm_ap_start,
  input  logic                   msm_ap_ready,
  input  logic                   msm_ap_done,
  output logic [ADDR_WIDTH-1:0]  batch_offset,
  output logic [BATCH_WIDTH-1:0] batch_idx,
  output logic                   busy,
  output logic                   done_pulse,
  output logic                   status_aborted,
  output logic                   status_timeout,
  output logic [CYC_WIDTH-1:0]   cycle_count
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  msm_seq_state_e state_q, state_d;
  logic [BATCH_WIDTH-1:0] num_q, num_d;
  logic [BATCH_WIDTH-1:0] batch_idx_q, batch_idx_d;
  logic [ADDR_WIDTH-1:0]  batch_offset_q, batch_offset_d;
  logic [CYC_WIDTH-1:0]   cycle_count_q, cycle_count_d;
  logic status_aborted_q, status_aborted_d;
  logic status_timeout_q, status_timeout_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic done_pulse_q, done_pulse_d;
  logic cmd_ready_q, cmd_ready_d;
  logic batch_end;
  logic wd_expired;

`ifdef MSM_SEQ_WATCHDOG_EN
  logic wd_clear;
  // A same-cycle ready+done relaunch stays in LAUNCH but still starts a new batch.
  assign wd_clear = (state_d == LAUNCH) && ((state_q != LAUNCH) || msm_ap_ready);

  msm_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .clear   (wd_clear),
    .enable  ((state_q == LAUNCH) || (state_q == WAIT)),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d          = state_q;
    num_d            = num_q;
    batch_idx_d      = batch_idx_q;
    batch_offset_d   = batch_offset_q;
    cycle_count_d    = cycle_count_q;
    status_aborted_d = status_aborted_q;
    status_timeout_d = status_timeout_q;
    batch_end        = 1'b0;

    if (((state_q == LAUNCH) || (state_q == WAIT)) && !(&cycle_count_q)) begin
      cycle_count_d = cycle_count_q + CYC_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          num_d            = cmd_num_batches;
          batch_idx_d      = '0;
          batch_offset_d   = cmd_base_addr;
          cycle_count_d    = '0;
          status_aborted_d = 1'b0;
          status_timeout_d = 1'b0;
          state_d          = (cmd_num_batches == '0) ? FINISH : LAUNCH;
        end
      end
      LAUNCH: begin
        if (msm_ap_ready) begin
          state_d   = WAIT;
          batch_end = msm_ap_done;
        end else if (abort) begin
          status_aborted_d = 1'b1;
          state_d          = FINISH;
        end else if (wd_expired) begin
          status_timeout_d = 1'b1;
          state_d          = FINISH;
        end
      end
      WAIT: begin
        if (msm_ap_done) begin
          batch_end = 1'b1;
        end else if (wd_expired) begin
          status_timeout_d = 1'b1;
          state_d          = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared by WAIT-done and the LAUNCH ready+done shortcut.
    if (batch_end) begin
      if (abort || (batch_idx_q == num_q - BATCH_WIDTH'(1))) begin
        status_aborted_d = abort;
        state_d          = FINISH;
      end else begin
        batch_idx_d    = batch_idx_q + BATCH_WIDTH'(1);
        batch_offset_d = batch_offset_q + ADDR_WIDTH'(MEM_SIZE);
        state_d        = LAUNCH;
      end
    end

    start_d      = (state_d == LAUNCH);
    busy_d       = (state_d != IDLE);
    done_pulse_d = (state_d == FINISH);
    cmd_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q          <= IDLE;
      num_q            <= '0;
      batch_idx_q      <= '0;
      batch_offset_q   <= '0;
      cycle_count_q    <= '0;
      status_aborted_q <= 1'b0;
      status_timeout_q <= 1'b0;
      start_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_pulse_q     <= 1'b0;
      cmd_ready_q      <= 1'b1;
    end else begin
      state_q          <= state_d;
      num_q            <= num_d;
      batch_idx_q      <= batch_idx_d;
      batch_offset_q   <= batch_offset_d;
      cycle_count_q    <= cycle_count_d;
      status_aborted_q <= status_aborted_d;
      status_timeout_q <= status_timeout_d;
      start_q          <= start_d;
      busy_q           <= busy_d;
      done_pulse_q     <= done_pulse_d;
      cmd_ready_q      <= cmd_ready_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign msm_ap_start   = start_q;
  assign batch_offset   = batch_offset_q;
  assign batch_idx      = batch_idx_q;
  assign busy           = busy_q;
  assign done_pulse     = done_pulse_q;
  assign status_aborted = status_aborted_q;
  assign status_timeout = status_timeout_q;
  assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_msm_batch_sequencer.sv
// Scoreboard bench for msm_batch_sequencer: a 16-bit instance plus an 8-bit
// address instance run in lockstep to cover offset wrap at both widths.
module tb_msm_batch_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_num_batches = '0;
  logic [15:0] cmd_base_addr = '0;
  logic [7:0]  base8 = '0;
  logic        abort = 1'b0;
  logic        msm_ap_ready = 1'b0;
  logic        msm_ap_done = 1'b0;

  logic        cmd_ready, msm_ap_start, busy, done_pulse, status_aborted, status_timeout;
  logic [15:0] batch_offset;
  logic [7:0]  batch_idx;
  logic [31:0] cycle_count;

  logic        cmd_ready8, msm_ap_start8, busy8, done_pulse8, status_aborted8, status_timeout8;
  logic [7:0]  batch_offset8;
  logic [7:0]  batch_idx8;
  logic [31:0] cycle_count8;

  msm_batch_sequencer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_batches(cmd_num_batches), .cmd_base_addr(cmd_base_addr),
    .abort(abort),
    .msm_ap_start(msm_ap_start), .msm_ap_ready(msm_ap_ready), .msm_ap_done(msm_ap_done),
    .batch_offset(batch_offset), .batch_idx(batch_idx),
    .busy(busy), .done_pulse(done_pulse),
    .status_aborted(status_aborted), .status_timeout(status_timeout),
    .cycle_count(cycle_count)
  );

  msm_batch_sequencer #(.ADDR_WIDTH(8)) dut8 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
    .cmd_num_batches(cmd_num_batches), .cmd_base_addr(base8),
    .abort(abort),
    .msm_ap_start(msm_ap_start8), .msm_ap_ready(msm_ap_ready), .msm_ap_done(msm_ap_done),
    .batch_offset(batch_offset8), .batch_idx(batch_idx8),
    .busy(busy8), .done_pulse(done_pulse8),
    .status_aborted(status_aborted8), .status_timeout(status_timeout8),
    .cycle_count(cycle_count8)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct { int idx; int off; int off8; } launch_t;
  typedef struct { int idx; int off; int off8; int aborted; int count; } done_t;

  launch_t lq[$];
  done_t   dq[$];
  int checks = 0;
  int failures = 0;
  int r_dly = 1;
  int d_dly = 1;
  bit same_cyc = 1'b0;
  int accept_cyc = 0;
  bit saw_wait = 1'b0;
  bit saw_start = 1'b0;
  bit prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s unexpected event (t=%0t)", name, $time);
  endtask

  // Core model: ready after r_dly cycles of start, done d_dly cycles later.
  initial begin : core_model
    int n;
    forever begin
      @(posedge ap_clk); #1;
      if (msm_ap_start) begin
        n = 0;
        while (n < r_dly && msm_ap_start) begin
          @(posedge ap_clk); #1;
          n++;
        end
        if (msm_ap_start) begin
          msm_ap_ready = 1'b1;
          msm_ap_done  = same_cyc;
          @(posedge ap_clk); #1;
          msm_ap_ready = 1'b0;
          msm_ap_done  = 1'b0;
          if (!same_cyc) begin
            repeat (d_dly) @(posedge ap_clk);
            #1 msm_ap_done = 1'b1;
            @(posedge ap_clk); #1;
            msm_ap_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops and compares on every launch handshake and completion.
  initial begin : monitor
    launch_t l;
    done_t   d;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_done = 1'b0;
        continue;
      end
      if (busy && !msm_ap_start && !done_pulse) saw_wait = 1'b1;
      if (msm_ap_start) saw_start = 1'b1;
      if (msm_ap_start && msm_ap_ready) begin
        if (lq.size() == 0) begin
          fail_event("launch");
        end else begin
          l = lq.pop_front();
          chk("launch_idx", batch_idx, l.idx);
          chk("launch_offset", batch_offset, l.off);
          chk("launch_offset8", batch_offset8, l.off8);
        end
      end
      if (done_pulse) begin
        if (prev_done) begin
          fail_event("done_pulse_width");
        end else if (dq.size() == 0) begin
          fail_event("done_pulse");
        end else begin
          d = dq.pop_front();
          chk("done_idx", batch_idx, d.idx);
          chk("done_idx8", batch_idx8, d.idx);
          chk("done_offset", batch_offset, d.off);
          chk("done_offset8", batch_offset8, d.off8);
          chk("done_aborted", status_aborted, d.aborted);
          chk("done_timeout", status_timeout, 0);
          chk("done_cycle_count", cycle_count, d.count);
          chk("done_latency", cyc - accept_cyc, d.count);
          chk("done_busy", busy, 1);
        end
      end
      prev_done = done_pulse;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_start"}, msm_ap_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_pulse"}, done_pulse, 0);
    chk({tag, "_aborted"}, status_aborted, 0);
    chk({tag, "_timeout"}, status_timeout, 0);
    chk({tag, "_batch_idx"}, batch_idx, 0);
    chk({tag, "_offset"}, batch_offset, 0);
    chk({tag, "_offset8"}, batch_offset8, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  task automatic issue(input logic [7:0] num, input logic [15:0] base,
                       input logic [7:0] b8, input bit ab);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_num_batches = num;
    cmd_base_addr   = base;
    base8           = b8;
    abort           = ab;
    cmd_valid       = 1'b1;
    @(posedge ap_clk); #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_when_busy", cmd_ready, 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_pulse && n < budget) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("done_within_budget", done_pulse, 1);
    @(posedge ap_clk); #1;
  endtask

  initial begin : global_limit
    #100000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    int n;
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 check_reset_values("reset");
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Single batch, base 0x40.
    r_dly = 2; d_dly = 3; same_cyc = 1'b0;
    lq.push_back('{0, 'h40, 'h40});
    dq.push_back('{0, 'h40, 'h40, 0, 7});
    issue(8'd1, 16'h0040, 8'h40, 1'b0);
    wait_done(100);

    // Three batches from base 0.
    r_dly = 1; d_dly = 1;
    lq.push_back('{0, 0, 0});
    lq.push_back('{1, 16, 16});
    lq.push_back('{2, 32, 32});
    dq.push_back('{2, 32, 32, 0, 14});
    issue(8'd3, 16'h0000, 8'h00, 1'b0);
    wait_done(100);

    // Ready and done together in LAUNCH.
    r_dly = 1; same_cyc = 1'b1; saw_wait = 1'b0;
    lq.push_back('{0, 'h100, 'h00});
    lq.push_back('{1, 'h110, 'h10});
    dq.push_back('{1, 'h110, 'h10, 0, 5});
    issue(8'd2, 16'h0100, 8'h00, 1'b0);
    wait_done(100);
    chk("same_cycle_no_wait", saw_wait, 0);
    same_cyc = 1'b0;

    // Zero batches.
    saw_start = 1'b0;
    dq.push_back('{0, 'h1234, 'h34, 0, 0});
    issue(8'd0, 16'h1234, 8'h34, 1'b0);
    wait_done(20);
    chk("num0_no_start", saw_start, 0);

    // Abort during WAIT of batch 1 of 4.
    r_dly = 1; d_dly = 4;
    lq.push_back('{0, 'h200, 'h00});
    lq.push_back('{1, 'h210, 'h10});
    dq.push_back('{1, 'h210, 'h10, 1, 15});
    issue(8'd4, 16'h0200, 8'h00, 1'b0);
    n = 0;
    while (!(busy && !msm_ap_start && batch_idx == 8'd1) && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("reached_wait_batch1", busy && !msm_ap_start && batch_idx == 8'd1, 1);
    abort = 1'b1;
    wait_done(100);
    abort = 1'b0;

    // Abort while LAUNCH waits for ready: no launch at all.
    r_dly = 20; d_dly = 1;
    dq.push_back('{0, 'h300, 'h00, 1, 1});
    issue(8'd2, 16'h0300, 8'h00, 1'b1);
    wait_done(50);
    abort = 1'b0;
    repeat (25) @(posedge ap_clk);
    #1;

    // Offset wrap at 16 and 8 address bits.
    r_dly = 0; d_dly = 0;
    lq.push_back('{0, 'hFFF8, 'hF8});
    lq.push_back('{1, 'h0008, 'h08});
    dq.push_back('{1, 'h0008, 'h08, 0, 5});
    issue(8'd2, 16'hFFF8, 8'hF8, 1'b0);
    wait_done(100);

    // Asynchronous reset in the middle of WAIT; the stray done afterwards is ignored.
    r_dly = 0; d_dly = 10;
    lq.push_back('{0, 'h500, 'h00});
    issue(8'd3, 16'h0500, 8'h00, 1'b0);
    n = 0;
    while (!(busy && !msm_ap_start) && n < 50) begin
      @(posedge ap_clk); #1;
      n++;
    end
    chk("reached_wait_before_reset", busy && !msm_ap_start, 1);
    #2 ap_rst_n = 1'b0;
    #1 check_reset_values("midrun_reset");
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (20) @(posedge ap_clk);
    #1 chk("idle_after_stray_done", busy, 0);

    repeat (3) @(posedge ap_clk);
    #1;
    chk("launch_queue_empty", lq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
